pipe_issue: RTL and testbench

- Fetch/issue stage sitting directly upstream of the four-stage register-read/ALU/writeback/store pipeline.
- Holds a small program memory and steps a PC through it.
- Decodes each 24-bit instruction into rs1/rs2/rd/func/addr, which drive the pipeline's operand inputs.
- The pipeline has no forwarding and no valid qualifier, so this block detects RAW hazards and substitutes harmless NOP bubbles.

---
 rtl/pipe_pkg.sv | 54 +++++
 rtl/pipe_issue_if.sv | 35 +++
 rtl/pipe_scoreboard.sv | 45 ++++
 rtl/pipe_issue.sv | 160 ++++++++++++++++
 tb/tb_pipe_issue.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipe_issue fetch/issue stage:
// instruction layout, func codes, NOP encoding and FSM state type.
package pipe_pkg;

  localparam int INSTR_W  = 24;
  localparam int FUNC_W   = 4;
  localparam int REG_W    = 4;
  localparam int ADDR_W   = 8;
  localparam int FUNC_LSB = 20;
  localparam int RD_LSB   = 16;
  localparam int RS1_LSB  = 12;
  localparam int RS2_LSB  = 8;
  localparam int ADDR_LSB = 0;

  localparam logic [FUNC_W-1:0] FUNC_OP0  = 4'd0;
  localparam logic [FUNC_W-1:0] FUNC_OP1  = 4'd1;
  localparam logic [FUNC_W-1:0] FUNC_OP2  = 4'd2;
  localparam logic [FUNC_W-1:0] FUNC_OP3  = 4'd3;
  localparam logic [FUNC_W-1:0] FUNC_OP4  = 4'd4;
  localparam logic [FUNC_W-1:0] FUNC_OP5  = 4'd5;
  localparam logic [FUNC_W-1:0] FUNC_OP6  = 4'd6;
  localparam logic [FUNC_W-1:0] FUNC_OP7  = 4'd7;
  localparam logic [FUNC_W-1:0] FUNC_OP8  = 4'd8;
  localparam logic [FUNC_W-1:0] FUNC_OP9  = 4'd9;
  localparam logic [FUNC_W-1:0] FUNC_OP10 = 4'd10;
  localparam logic [FUNC_W-1:0] FUNC_OP11 = 4'd11;
  localparam logic [FUNC_W-1:0] FUNC_HALT = 4'hF;

  // A bubble passes register 0 through to the reserved scratch address.
  localparam logic [FUNC_W-1:0] NOP_FUNC         = FUNC_OP3;
  localparam logic [REG_W-1:0]  NOP_REG          = 4'd0;
  localparam logic [ADDR_W-1:0] NOP_ADDR_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [ADDR_W-1:0] addr;
  } instr_t;

  function automatic instr_t nopInstr(input logic [ADDR_W-1:0] nopAddr);
    instr_t n;
    n.func = NOP_FUNC;
    n.rd   = NOP_REG;
    n.rs1  = NOP_REG;
    n.rs2  = NOP_REG;
    n.addr = nopAddr;
    return n;
  endfunction

endpackage

// File: rtl/pipe_issue_if.sv
// Programming/control inputs and decoded issue outputs of pipe_issue.
// PIPE_ISSUE_STATS_EN adds the issue/stall counter signals.
interface pipe_issue_if #(parameter int AW = 6);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [23:0]   prog_data;
  logic          start;
  logic [AW-1:0] start_pc;
  logic          stop;
  logic [3:0]    rs1;
  logic [3:0]    rs2;
  logic [3:0]    rd;
  logic [3:0]    func;
  logic [7:0]    addr;
  logic          issue_vld;
  logic          busy;
  logic          done;
  logic [AW-1:0] pc;
`ifdef PIPE_ISSUE_STATS_EN
  logic [15:0]   issue_cnt;
  logic [15:0]   stall_cnt;

  modport master (output prog_we, prog_addr, prog_data, start, start_pc, stop,
                  input  rs1, rs2, rd, func, addr, issue_vld, busy, done, pc,
                         issue_cnt, stall_cnt);
  modport slave  (input  prog_we, prog_addr, prog_data, start, start_pc, stop,
                  output rs1, rs2, rd, func, addr, issue_vld, busy, done, pc,
                         issue_cnt, stall_cnt);
`else
  modport master (output prog_we, prog_addr, prog_data, start, start_pc, stop,
                  input  rs1, rs2, rd, func, addr, issue_vld, busy, done, pc);
  modport slave  (input  prog_we, prog_addr, prog_data, start, start_pc, stop,
                  output rs1, rs2, rd, func, addr, issue_vld, busy, done, pc);
`endif
endinterface

// File: rtl/pipe_scoreboard.sv
// Shift register of the most recent issue slots {valid, rd}; flags a match
// against either source register of the instruction being fetched.
module pipe_scoreboard #(
  parameter int DEPTH = 2
) (
  input  logic       clk1,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic       clear_i,
  input  logic       pushVld_i,
  input  logic [3:0] pushRd_i,
  input  logic [3:0] rs1_i,
  input  logic [3:0] rs2_i,
  output logic       match_o
);

  logic [DEPTH-1:0] vld_q;
  logic [3:0]       rd_q [DEPTH];

  // Entry 0 is the newest slot.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) rd_q[i] <= '0;
    end else if (clear_i) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) rd_q[i] <= '0;
    end else if (push_i) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        vld_q[i] <= vld_q[i-1];
        rd_q[i]  <= rd_q[i-1];
      end
      vld_q[0] <= pushVld_i;
      rd_q[0]  <= pushRd_i;
    end
  end

  always_comb begin
    match_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && ((rd_q[i] == rs1_i) || (rd_q[i] == rs2_i))) match_o = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_issue.sv
// Fetch/issue stage: steps a PC through program memory, decodes, and inserts
// NOP bubbles on RAW hazards. Define PIPE_ISSUE_STATS_EN for issue/stall counters.
module pipe_issue
  import pipe_pkg::*;
#(
  parameter int         AW        = 6,
  parameter int         HAZ_DEPTH = 2,
  parameter logic [7:0] NOP_ADDR  = NOP_ADDR_DEFAULT
) (
  input logic         clk1,
  input logic         rst_n,
  pipe_issue_if.slave bus
);

  localparam logic [1:0] DRAIN_LAST = 2'(HAZ_DEPTH - 1);

  logic [INSTR_W-1:0] mem [2**AW];

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  instr_t        out_q, out_d;
  logic          vld_q, vld_d;
  logic [1:0]    drainCnt_q, drainCnt_d;
  instr_t        fetch;
  logic          busy;
  logic          hazard;
  logic          sbPush;
  logic          sbClear;

  assign busy  = (state_q == RUN) || (state_q == DRAIN);
  assign fetch = instr_t'(mem[pc_q]);

  always_ff @(posedge clk1) begin
    if (bus.prog_we && !busy) mem[bus.prog_addr] <= bus.prog_data;
  end

  pipe_scoreboard #(.DEPTH(HAZ_DEPTH)) u_sb (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .push_i    (sbPush),
    .clear_i   (sbClear),
    .pushVld_i (vld_d),
    .pushRd_i  (out_d.rd),
    .rs1_i     (fetch.rs1),
    .rs2_i     (fetch.rs2),
    .match_o   (hazard)
  );

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // stop outranks hazard and HALT; a stalled HALT is only recognised once clear.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (bus.start) state_d = RUN;
      RUN: begin
        if (bus.stop)                            state_d = IDLE;
        else if (!hazard && fetch.func == FUNC_HALT) state_d = DRAIN;
      end
      DRAIN: begin
        if (bus.stop)                      state_d = IDLE;
        else if (drainCnt_q == DRAIN_LAST) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_d      = nopInstr(NOP_ADDR);
    vld_d      = 1'b0;
    pc_d       = pc_q;
    drainCnt_d = '0;
    sbPush     = 1'b0;
    sbClear    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          pc_d    = bus.start_pc;
          sbClear = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop) begin
          sbClear = 1'b1;
        end else begin
          sbPush = 1'b1;
          if (!hazard && fetch.func != FUNC_HALT) begin
            out_d = fetch;
            vld_d = 1'b1;
            pc_d  = pc_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (bus.stop) begin
          sbClear = 1'b1;
        end else begin
          sbPush     = 1'b1;
          drainCnt_d = drainCnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= '0;
      out_q      <= nopInstr(NOP_ADDR);
      vld_q      <= 1'b0;
      drainCnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      out_q      <= out_d;
      vld_q      <= vld_d;
      drainCnt_q <= drainCnt_d;
    end
  end

  assign bus.rs1       = out_q.rs1;
  assign bus.rs2       = out_q.rs2;
  assign bus.rd        = out_q.rd;
  assign bus.func      = out_q.func;
  assign bus.addr      = out_q.addr;
  assign bus.issue_vld = vld_q;
  assign bus.busy      = busy;
  assign bus.done      = (state_q == DONE);
  assign bus.pc        = pc_q;

`ifdef PIPE_ISSUE_STATS_EN
  logic [15:0] issueCnt_q;
  logic [15:0] stallCnt_q;
  logic        startGo;
  logic        stallEvt;

  assign startGo  = bus.start && !busy;
  assign stallEvt = (state_q == RUN) && !bus.stop && hazard;

  // Only hazard bubbles count as stalls; HALT and DRAIN NOPs do not.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      issueCnt_q <= '0;
      stallCnt_q <= '0;
    end else if (startGo) begin
      issueCnt_q <= '0;
      stallCnt_q <= '0;
    end else begin
      if (vld_d && issueCnt_q != 16'hFFFF)    issueCnt_q <= issueCnt_q + 16'd1;
      if (stallEvt && stallCnt_q != 16'hFFFF) stallCnt_q <= stallCnt_q + 16'd1;
    end
  end

  assign bus.issue_cnt = issueCnt_q;
  assign bus.stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_pipe_issue.sv
// Self-checking bench for pipe_issue: directed scenarios plus random programs,
// compared cycle by cycle against a program-level reference model.
module tb_pipe_issue;

  localparam int         AW    = 6;
  localparam int         DEPTH = 64;
  localparam int         HAZ   = 2;
  localparam logic [7:0] NOPA  = 8'hFF;
  localparam logic [23:0] NOP_WORD  = {4'd3, 4'd0, 4'd0, 4'd0, NOPA};
  localparam logic [23:0] HALT_WORD = 24'hF00000;

  typedef struct packed {
    logic          vld;
    logic [23:0]   word;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
  } rec_t;

  logic clk1;
  logic rst_n;

  int checks;
  int errors;
  int expIssue;
  int expStall;
  int obsIssue;

  logic [23:0] mdlMem [DEPTH];
  rec_t        trace[$];

  pipe_issue_if #(.AW(AW)) bus ();

  pipe_issue #(
    .AW        (AW),
    .HAZ_DEPTH (HAZ),
    .NOP_ADDR  (NOPA)
  ) dut (
    .clk1  (clk1),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [AW-1:0] a, input logic [23:0] d,
                               input logic st, input logic [AW-1:0] spc, input logic sp);
    bus.prog_we   = we;
    bus.prog_addr = a;
    bus.prog_data = d;
    bus.start     = st;
    bus.start_pc  = spc;
    bus.stop      = sp;
    @(posedge clk1);
    #1;
  endtask

  task automatic writeMem(input int a, input logic [23:0] d);
    mdlMem[a % DEPTH] = d;
    applyStimulus(1'b1, AW'(a % DEPTH), d, 1'b0, '0, 1'b0);
  endtask

  function automatic logic [23:0] obsWord();
    return {bus.func, bus.rd, bus.rs1, bus.rs2, bus.addr};
  endfunction

  function automatic rec_t mk(input logic v, input logic [23:0] w, input int p,
                              input logic b, input logic dn);
    rec_t r;
    r.vld  = v;
    r.word = w;
    r.pc   = AW'(p);
    r.busy = b;
    r.done = dn;
    return r;
  endfunction

  // Program-level model: one record per clock after the start edge, until DONE.
  function automatic void buildTrace(input int startPc);
    int pcm;
    int hist[$];
    bit halted;
    int guard;
    logic [23:0] w;
    int rs1;
    int rs2;
    bit haz;
    trace.delete();
    expIssue = 0;
    expStall = 0;
    pcm    = startPc;
    halted = 0;
    guard  = 0;
    while (!halted && guard < 2000) begin
      guard++;
      w   = mdlMem[pcm];
      rs1 = int'(w[15:12]);
      rs2 = int'(w[11:8]);
      haz = 0;
      for (int i = 0; i < HAZ && i < hist.size(); i++)
        if (hist[i] == rs1 || hist[i] == rs2) haz = 1;
      if (haz) begin
        trace.push_back(mk(1'b0, NOP_WORD, pcm, 1'b1, 1'b0));
        hist.push_front(-1);
        expStall++;
      end else if (w[23:20] == 4'hF) begin
        halted = 1;
        for (int d = 0; d < HAZ; d++) trace.push_back(mk(1'b0, NOP_WORD, pcm, 1'b1, 1'b0));
        trace.push_back(mk(1'b0, NOP_WORD, pcm, 1'b0, 1'b1));
      end else begin
        pcm = (pcm + 1) % DEPTH;
        trace.push_back(mk(1'b1, w, pcm, 1'b1, 1'b0));
        hist.push_front(int'(w[19:16]));
        expIssue++;
      end
    end
  endfunction

  task automatic runTrace(input int startPc, input string tag, input logic doWrite,
                          input logic [23:0] wword);
    if (doWrite) mdlMem[startPc] = wword;
    buildTrace(startPc);
    obsIssue = 0;
    applyStimulus(doWrite, AW'(startPc), wword, 1'b1, AW'(startPc), 1'b0);
    checkOutput({tag, "/start_busy"}, 32'(bus.busy), 32'd1);
    checkOutput({tag, "/start_vld"}, 32'(bus.issue_vld), 32'd0);
    checkOutput({tag, "/start_pc"}, 32'(bus.pc), 32'(startPc));
    foreach (trace[i]) begin
      applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
      if (bus.issue_vld === 1'b1) obsIssue++;
      checkOutput($sformatf("%s/c%0d/vld", tag, i), 32'(bus.issue_vld), 32'(trace[i].vld));
      checkOutput($sformatf("%s/c%0d/word", tag, i), 32'(obsWord()), 32'(trace[i].word));
      checkOutput($sformatf("%s/c%0d/pc", tag, i), 32'(bus.pc), 32'(trace[i].pc));
      checkOutput($sformatf("%s/c%0d/busy", tag, i), 32'(bus.busy), 32'(trace[i].busy));
      checkOutput($sformatf("%s/c%0d/done", tag, i), 32'(bus.done), 32'(trace[i].done));
    end
`ifdef PIPE_ISSUE_STATS_EN
    checkOutput({tag, "/issue_cnt"}, 32'(bus.issue_cnt), 32'(expIssue));
    checkOutput({tag, "/stall_cnt"}, 32'(bus.stall_cnt), 32'(expStall));
`endif
  endtask

  initial begin
    int n;
    int sp;
    checks = 0;
    errors = 0;

    $display("[TB] reset values");
    rst_n         = 1'b0;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.start     = 1'b0;
    bus.start_pc  = '0;
    bus.stop      = 1'b0;
    #12;
    checkOutput("rst/vld", 32'(bus.issue_vld), 32'd0);
    checkOutput("rst/word", 32'(obsWord()), 32'(NOP_WORD));
    checkOutput("rst/busy", 32'(bus.busy), 32'd0);
    checkOutput("rst/done", 32'(bus.done), 32'd0);
    checkOutput("rst/pc", 32'(bus.pc), 32'd0);
    rst_n = 1'b1;

    $display("[TB] independent ops");
    writeMem(0, 24'h012300);
    writeMem(1, 24'h145601);
    writeMem(2, HALT_WORD);
    runTrace(0, "indep", 1'b0, '0);
    checkOutput("indep/issued", 32'(obsIssue), 32'd2);

    $display("[TB] stop in RUN, write while busy ignored");
    applyStimulus(1'b0, '0, '0, 1'b1, '0, 1'b0);
    applyStimulus(1'b1, AW'(1), HALT_WORD, 1'b0, '0, 1'b0);
    checkOutput("stop/run1_vld", 32'(bus.issue_vld), 32'd1);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    checkOutput("stop/busy", 32'(bus.busy), 32'd0);
    checkOutput("stop/done", 32'(bus.done), 32'd0);
    checkOutput("stop/vld", 32'(bus.issue_vld), 32'd0);
    checkOutput("stop/word", 32'(obsWord()), 32'(NOP_WORD));
    runTrace(0, "stopRerun", 1'b0, '0);
    checkOutput("stopRerun/issued", 32'(obsIssue), 32'd2);

    $display("[TB] RAW hazard");
    writeMem(1, 24'h141601);
    runTrace(0, "raw", 1'b0, '0);
    checkOutput("raw/issued", 32'(obsIssue), 32'd2);
`ifdef PIPE_ISSUE_STATS_EN
    checkOutput("raw/issue_cnt_fixed", 32'(bus.issue_cnt), 32'd2);
    checkOutput("raw/stall_cnt_fixed", 32'(bus.stall_cnt), 32'd2);
`endif

    $display("[TB] reset mid-run");
    applyStimulus(1'b0, '0, '0, 1'b1, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst/vld", 32'(bus.issue_vld), 32'd0);
    checkOutput("midrst/word", 32'(obsWord()), 32'(NOP_WORD));
    checkOutput("midrst/busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst/pc", 32'(bus.pc), 32'd0);
    #1;
    rst_n = 1'b1;
    runTrace(0, "rstRerun", 1'b0, '0);
    checkOutput("rstRerun/issued", 32'(obsIssue), 32'd2);

    $display("[TB] pc wrap");
    writeMem(63, 24'h012300);
    writeMem(0, HALT_WORD);
    runTrace(63, "wrap", 1'b0, '0);
    checkOutput("wrap/issued", 32'(obsIssue), 32'd1);

    $display("[TB] same-cycle write and start");
    writeMem(11, HALT_WORD);
    runTrace(10, "sameCyc", 1'b1, 24'h0567AA);
    checkOutput("sameCyc/issued", 32'(obsIssue), 32'd1);

    $display("[TB] random programs");
    for (int p = 0; p < 20; p++) begin
      n  = $urandom_range(1, 8);
      sp = $urandom_range(0, DEPTH - 1);
      for (int i = 0; i < n; i++)
        writeMem(sp + i, {4'($urandom_range(0, 14)), 4'($urandom_range(0, 3)),
                          4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 8'($urandom)});
      writeMem(sp + n, {4'hF, 4'd0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 8'd0});
      runTrace(sp, $sformatf("rand%0d", p), 1'b0, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
